// File: rtl/brc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | brc_pkg : shared types, funct3 codes and taken decode for brc_seq |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
package brc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } brc_state_t;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Signedness is already folded into the operands, so LT/LTU share decode.
    function automatic logic brc_taken(input logic [2:0] op, input logic less, input logic equal);
        logic taken;
        case (op)
            BR_EQ:   taken = equal;
            BR_NE:   taken = !equal;
            BR_LT:   taken = less;
            BR_GE:   taken = !less;
            BR_LTU:  taken = less;
            BR_GEU:  taken = !less;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/brc_chunk_cmp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | brc_chunk_cmp : combinational unsigned CHUNK-bit compare (lt, eq) |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module brc_chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             eq
);

    assign lt = (a < b);
    assign eq = (a == b);

endmodule
`default_nettype wire

// File: rtl/brc_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | brc_seq : multi-cycle MSB-first chunked branch comparator          |
// | Option macro: BRC_EARLY_EXIT_EN (stop scan at first difference)    |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module brc_seq
    import brc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic             i_br_un,
    input  logic [2:0]       i_br_op,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_br_less,
    output logic             o_br_equal,
    output logic             o_br_taken
);

    localparam int                NCHUNK   = WIDTH / CHUNK;
    localparam int                IDXW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0]  SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

    brc_state_t       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic             less_r;
    logic             eq_r;
    logic             decided;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             chunk_lt;
    logic             chunk_eq;
    logic             less_nxt;
    logic             eq_nxt;
    logic             scan_exit;

    assign a_chunk = CHUNK'(a_r >> (CHUNK * idx));
    assign b_chunk = CHUNK'(b_r >> (CHUNK * idx));

    brc_chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
        .a  (a_chunk),
        .b  (b_chunk),
        .lt (chunk_lt),
        .eq (chunk_eq)
    );

    // First differing chunk (from the top) decides; later chunks are ignored.
    always_comb begin
        less_nxt = less_r;
        eq_nxt   = eq_r;
        if (!decided) begin
            if (!chunk_eq) begin
                less_nxt = chunk_lt;
                eq_nxt   = 1'b0;
            end else if (idx == '0) begin
                less_nxt = 1'b0;
                eq_nxt   = 1'b1;
            end
        end
    end

`ifdef BRC_EARLY_EXIT_EN
    assign scan_exit = (idx == '0) || (!decided && !chunk_eq);
`else
    assign scan_exit = (idx == '0);
`endif

    assign o_ready = (state == IDLE) && !i_rst;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            idx        <= LAST_IDX;
            a_r        <= '0;
            b_r        <= '0;
            op_r       <= '0;
            less_r     <= 1'b0;
            eq_r       <= 1'b0;
            decided    <= 1'b0;
            o_valid    <= 1'b0;
            o_br_less  <= 1'b0;
            o_br_equal <= 1'b0;
            o_br_taken <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        // Flipping the sign bits turns a signed compare into unsigned.
                        a_r     <= i_rs1_data ^ (i_br_un ? '0 : SIGN_BIT);
                        b_r     <= i_rs2_data ^ (i_br_un ? '0 : SIGN_BIT);
                        op_r    <= i_br_op;
                        idx     <= LAST_IDX;
                        less_r  <= 1'b0;
                        eq_r    <= 1'b0;
                        decided <= 1'b0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    less_r <= less_nxt;
                    eq_r   <= eq_nxt;
                    if (!chunk_eq) begin
                        decided <= 1'b1;
                    end
                    if (scan_exit) begin
                        state      <= DONE;
                        o_valid    <= 1'b1;
                        o_br_less  <= less_nxt;
                        o_br_equal <= eq_nxt;
                        o_br_taken <= brc_taken(op_r, less_nxt, eq_nxt);
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_brc_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_brc_seq : directed self-checking bench for brc_seq (32/8)       |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module tb_brc_seq;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        br_un;
    logic [2:0]  br_op;
    logic        valid_out;
    logic        ready_in;
    logic        br_less;
    logic        br_equal;
    logic        br_taken;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef BRC_EARLY_EXIT_EN
    localparam int LAT_TOP  = 2;
    localparam int LAT_MID1 = 4;
`else
    localparam int LAT_TOP  = 5;
    localparam int LAT_MID1 = 5;
`endif

    brc_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (valid_in),
        .o_ready    (ready_out),
        .i_rs1_data (rs1),
        .i_rs2_data (rs2),
        .i_br_un    (br_un),
        .i_br_op    (br_op),
        .o_valid    (valid_out),
        .i_ready    (ready_in),
        .o_br_less  (br_less),
        .o_br_equal (br_equal),
        .o_br_taken (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for o_valid, check latency and results; leaves DUT in DONE.
    task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic un, input logic [2:0] op, input int exp_lat,
                         input logic e_less, input logic e_eq, input logic e_taken);
        int n;
        chk({tag, ".ready"}, 32'(ready_out), 32'd1);
        rs1 = a; rs2 = b; br_un = un; br_op = op; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        rs1 = ~a; rs2 = a; br_un = ~un; br_op = ~op;
        n = 1;
        while (!valid_out && n < 20) begin
            step();
            n++;
        end
        chk({tag, ".lat"},   32'(n),        32'(exp_lat));
        chk({tag, ".less"},  32'(br_less),  32'(e_less));
        chk({tag, ".eq"},    32'(br_equal), 32'(e_eq));
        chk({tag, ".taken"}, 32'(br_taken), 32'(e_taken));
    endtask

    task automatic release_result(input string tag);
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        chk({tag, ".vfall"}, 32'(valid_out), 32'd0);
        chk({tag, ".rrise"}, 32'(ready_out), 32'd1);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
        rs1 = '0; rs2 = '0; br_un = 1'b0; br_op = 3'b000;
        #12;
        chk("rst.ready", 32'(ready_out), 32'd0);
        chk("rst.valid", 32'(valid_out), 32'd0);
        chk("rst.out",   {29'd0, br_less, br_equal, br_taken}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rel.ready", 32'(ready_out), 32'd1);
        step();

        issue("s1", 32'h0000_0005, 32'h0000_0005, 1'b0, 3'b000, 5, 1'b0, 1'b1, 1'b1);
        release_result("s1");
        issue("s1b", 32'h0000_0005, 32'h0000_0005, 1'b1, 3'b001, 5, 1'b0, 1'b1, 1'b0);
        release_result("s1b");
        issue("s2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, LAT_TOP, 1'b1, 1'b0, 1'b1);
        release_result("s2");
        chk("s2.hold", 32'(br_less), 32'd1);
        issue("s3", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b110, LAT_TOP, 1'b0, 1'b0, 1'b0);
        release_result("s3");
        issue("s4", 32'h1234_5600, 32'h1234_5700, 1'b1, 3'b111, LAT_MID1, 1'b1, 1'b0, 1'b0);
        release_result("s4");
        issue("s4b", 32'h1234_5600, 32'h1234_5700, 1'b1, 3'b010, LAT_MID1, 1'b1, 1'b0, 1'b0);
        release_result("s4b");
        issue("s4c", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b101, LAT_TOP, 1'b1, 1'b0, 1'b0);
        release_result("s4c");

        // Backpressure: hold DONE while i_valid pulses with other operands
        issue("s5", 32'h1234_5600, 32'h1234_5700, 1'b1, 3'b110, LAT_MID1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            rs1 = 32'h0000_0009; rs2 = 32'h0000_0009; br_op = 3'b000; br_un = 1'b1;
            valid_in = (i != 1);
            step();
            chk("s5.valid", 32'(valid_out), 32'd1);
            chk("s5.ready", 32'(ready_out), 32'd0);
            chk("s5.res",   {29'd0, br_less, br_equal, br_taken}, 32'b100 | 32'b001);
        end
        valid_in = 1'b0;
        release_result("s5");
        chk("s5.held", {29'd0, br_less, br_equal, br_taken}, 32'b101);

        // Reset mid-scan discards the request and clears results at once
        rs1 = 32'h0000_0001; rs2 = 32'h0000_0002; br_un = 1'b1; br_op = 3'b110;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("s6.out",   {29'd0, br_less, br_equal, br_taken}, 32'd0);
        chk("s6.valid", 32'(valid_out), 32'd0);
        chk("s6.ready", 32'(ready_out), 32'd0);
        #6;
        rst = 1'b0;
        #1;
        chk("s6.rel", 32'(ready_out), 32'd1);
        step();
        issue("s6b", 32'h0000_0010, 32'h0000_0020, 1'b1, 3'b110, 5, 1'b1, 1'b0, 1'b1);
        release_result("s6b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
